fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning PC value loaded on reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0), meaning the bubble word injected on flush.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port stall  input  1  hazard-unit load-use stall: hold PC and the decode register.
REQ-006 SHALL have port branch_taken  input  1  branch/jump unit redirect request, resolved in decode.
REQ-007 SHALL have port branch_target  input  32  redirect address.
REQ-008 SHALL have port imem_addr  output  32  instruction memory address, equal to current PC.
REQ-009 SHALL have port imem_rdata  input  32  instruction word, combinational read of imem_addr.
REQ-010 SHALL have port id_instr  output  32  decode-stage instruction; rs1/rs2/rd/opcode fields feed the hazard unit.
REQ-011 SHALL have port id_pc  output  32  PC of id_instr.
REQ-012 SHALL have port id_pc_plus4  output  32  id_pc + 4, for jal/jalr link value.
REQ-013 SHALL have port id_valid  output  1  1 = id_instr is a real fetched instruction; 0 = bubble.
REQ-014 SHALL have port stall_cnt  output  32  number of cycles with stall asserted.
REQ-015 SHALL have port flush_cnt  output  32  number of accepted redirects.

Function
REQ-016 SHALL drive imem_addr from the PC register with zero added latency.
REQ-017 SHALL, each non-reset cycle, apply exactly one action, priority: stall > branch_taken > sequential.
REQ-018 SHALL, on stall=1, hold PC, id_instr, id_pc, id_pc_plus4, id_valid unchanged; branch_taken is ignored that cycle.
REQ-019 SHALL, on stall=0 and branch_taken=1, load PC with {branch_target[31:2],2'b00}, load id_instr with NOP_INSTR, id_valid with 0, id_pc and id_pc_plus4 with 0.
REQ-020 SHALL, on stall=0 and branch_taken=0, load PC with PC+4, id_instr with imem_rdata, id_pc with PC, id_pc_plus4 with PC+4, id_valid with 1.
REQ-021 SHALL compute all PC arithmetic modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000 with no flag.
REQ-022 SHALL increment stall_cnt by 1 on every non-reset cycle with stall=1, wrapping from 32'hFFFF_FFFF to 0.
REQ-023 SHALL increment flush_cnt by 1 on every non-reset cycle with stall=0 and branch_taken=1, wrapping at 2^32.
REQ-024 SHALL treat a redirect to the current PC (self-loop) as a normal redirect: bubble inserted, flush_cnt increments.
REQ-025 SHALL produce one bubble cycle per accepted redirect (branch penalty 1 cycle).

Reset
REQ-026 SHALL, while rst=1 at a rising edge, set PC=RESET_PC, id_instr=NOP_INSTR, id_pc=0, id_pc_plus4=0, id_valid=0, stall_cnt=0, flush_cnt=0, regardless of stall/branch_taken.
REQ-027 SHALL, on first cycle after rst deasserts, present imem_addr=RESET_PC and id_valid=0.
REQ-028 SHALL discard any in-flight stall or redirect when rst asserts mid-operation; no counter increments in reset cycles.

Structure
REQ-029 SHALL take RESET_PC default, NOP_INSTR encoding and the 32-bit word width from the shared pipeline package, also used by the decode and hazard logic.
REQ-030 SHALL contain one sub-module, if_id_reg, holding id_instr/id_pc/id_pc_plus4/id_valid with hold and flush inputs; PC register, next-PC select and counters in fetch_stage.

Verification
REQ-031 SHALL cover: reset, then 3 cycles stall=0 branch_taken=0 with imem returning 0xA,0xB,0xC -> imem_addr 0,4,8,C; id_instr A,B,C with id_pc 0,4,8, id_valid=1.
REQ-032 SHALL cover: at PC=0x10, stall=1 for 2 cycles -> PC stays 0x10, id_* frozen, stall_cnt=2, flush_cnt=0.
REQ-033 SHALL cover: at PC=0x20, branch_taken=1, branch_target=0x103 -> next PC=0x100, id_instr=0x00000013, id_valid=0, flush_cnt+1.
REQ-034 SHALL cover: stall=1 and branch_taken=1 same cycle -> hold wins, PC unchanged, flush_cnt unchanged; redirect accepted next cycle when stall=0.
REQ-035 SHALL cover: PC=0xFFFF_FFFC sequential -> PC=0x0, id_pc=0xFFFF_FFFC, id_pc_plus4=0x0.
REQ-036 SHALL cover: rst=1 asserted with stall=1 and PC=0x40, stall_cnt=5 -> PC=RESET_PC, counters 0, id_valid=0.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions: word width, reset/bubble constants and the
// fetch action encoding used by fetch, decode and hazard logic.
package fetch_stage_pkg;

  localparam int unsigned XLEN = 32;

  typedef logic [XLEN-1:0] word_t;

  localparam word_t RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam word_t NOP_INSTR_DEFAULT = 32'h0000_0013;  // addi x0,x0,0
  localparam word_t INSTR_BYTES       = 32'd4;

  typedef enum logic [1:0] {
    ACT_SEQ      = 2'd0,
    ACT_HOLD     = 2'd1,
    ACT_REDIRECT = 2'd2
  } fetch_act_e;

  typedef struct packed {
    word_t instr;
    word_t pc;
    word_t pc_plus4;
    logic  valid;
  } id_payload_t;

  function automatic word_t word_align(input word_t addr);
    return addr & ~word_t'(3);
  endfunction

  // Stall outranks a redirect so a held decode slot never loses its instruction.
  function automatic fetch_act_e decode_act(input logic stall, input logic branch_taken);
    if (stall)        return ACT_HOLD;
    if (branch_taken) return ACT_REDIRECT;
    return ACT_SEQ;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: hazard/branch controls, instruction memory port,
// decode-stage outputs and event counters.
interface fetch_stage_if;
  import fetch_stage_pkg::*;

  logic  stall;
  logic  branch_taken;
  word_t branch_target;
  word_t imem_addr;
  word_t imem_rdata;
  word_t id_instr;
  word_t id_pc;
  word_t id_pc_plus4;
  logic  id_valid;
  word_t stall_cnt;
  word_t flush_cnt;

  modport master (
    input  stall, branch_taken, branch_target, imem_rdata,
    output imem_addr, id_instr, id_pc, id_pc_plus4, id_valid, stall_cnt, flush_cnt
  );

  modport slave (
    output stall, branch_taken, branch_target, imem_rdata,
    input  imem_addr, id_instr, id_pc, id_pc_plus4, id_valid, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: holds on stall, loads a bubble on flush,
// otherwise captures the freshly fetched instruction.
module if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter word_t NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hold,
  input  logic        flush,
  input  id_payload_t load_data,
  output id_payload_t id_out
);

  localparam id_payload_t BUBBLE = '{
    instr:    NOP_INSTR,
    pc:       '0,
    pc_plus4: '0,
    valid:    1'b0
  };

  id_payload_t payload_d;
  id_payload_t payload_q;

  always_comb begin
    payload_d = payload_q;
    if (hold) begin
      payload_d = payload_q;
    end else if (flush) begin
      payload_d = BUBBLE;
    end else begin
      payload_d = load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      payload_q <= BUBBLE;
    end else begin
      payload_q <= payload_d;
    end
  end

  assign id_out = payload_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, next-PC select, IF/ID register and
// stall/flush event counters.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter word_t RESET_PC  = RESET_PC_DEFAULT,
  parameter word_t NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  fetch_stage_if.master   bus
);

  fetch_act_e  act;
  word_t       pc_d;
  word_t       pc_q;
  word_t       pc_seq;
  word_t       stall_cnt_d;
  word_t       stall_cnt_q;
  word_t       flush_cnt_d;
  word_t       flush_cnt_q;
  id_payload_t fetched;
  id_payload_t id_cur;

  assign act    = decode_act(bus.stall, bus.branch_taken);
  assign pc_seq = pc_q + INSTR_BYTES;  // wraps modulo 2^32

  always_comb begin
    pc_d        = pc_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    unique case (act)
      ACT_HOLD: begin
        stall_cnt_d = stall_cnt_q + 32'd1;
      end
      ACT_REDIRECT: begin
        pc_d        = word_align(bus.branch_target);
        flush_cnt_d = flush_cnt_q + 32'd1;
      end
      default: begin
        pc_d = pc_seq;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      pc_q        <= pc_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_comb begin
    fetched.instr    = bus.imem_rdata;
    fetched.pc       = pc_q;
    fetched.pc_plus4 = pc_seq;
    fetched.valid    = 1'b1;
  end

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk       (clk),
    .rst       (rst),
    .hold      (act == ACT_HOLD),
    .flush     (act == ACT_REDIRECT),
    .load_data (fetched),
    .id_out    (id_cur)
  );

  assign bus.imem_addr   = pc_q;
  assign bus.id_instr    = id_cur.instr;
  assign bus.id_pc       = id_cur.pc;
  assign bus.id_pc_plus4 = id_cur.pc_plus4;
  assign bus.id_valid    = id_cur.valid;
  assign bus.stall_cnt   = stall_cnt_q;
  assign bus.flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a randomized
// run against a cycle-level behavioural model of the fetch rules.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic [31:0] salt;
  int          n_checks;
  int          n_fail;

  fetch_stage_if bus ();

  fetch_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [31:0] imem_word(input logic [31:0] addr, input logic [31:0] s);
    case (addr)
      32'h0:   return 32'hA;
      32'h4:   return 32'hB;
      32'h8:   return 32'hC;
      default: return {addr[15:0], ~addr[31:16]} ^ s;
    endcase
  endfunction

  assign bus.imem_rdata = imem_word(bus.imem_addr, salt);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state, advanced once per clock from the fetch rules.
  logic [31:0] m_pc, m_instr, m_id_pc, m_id_pc4, m_sc, m_fc;
  logic        m_valid;

  task automatic model_step(input logic r, input logic s, input logic b, input logic [31:0] t);
    if (r) begin
      m_pc = 32'h0; m_instr = NOP; m_id_pc = 0; m_id_pc4 = 0; m_valid = 0; m_sc = 0; m_fc = 0;
    end else if (s) begin
      m_sc = m_sc + 1;
    end else if (b) begin
      m_pc = {t[31:2], 2'b00}; m_instr = NOP; m_id_pc = 0; m_id_pc4 = 0; m_valid = 0;
      m_fc = m_fc + 1;
    end else begin
      m_instr = imem_word(m_pc, salt); m_id_pc = m_pc; m_id_pc4 = m_pc + 4; m_valid = 1;
      m_pc = m_pc + 4;
    end
  endtask

  task automatic cyc(input logic r, input logic s, input logic b, input logic [31:0] t);
    rst = r; bus.stall = s; bus.branch_taken = b; bus.branch_target = t;
    model_step(r, s, b, t);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    cyc(1, 1, 1, 32'h55);
    cyc(1, 1, 1, 32'h77);
    n_checks++; if (bus.imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_pc got=%h exp=%h", bus.imem_addr, 32'h0); end
    n_checks++; if (bus.id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", bus.id_valid); end
    n_checks++; if (bus.id_instr !== NOP) begin n_fail++; $display("FAIL reset_instr got=%h exp=%h", bus.id_instr, NOP); end
    n_checks++; if ({bus.id_pc, bus.id_pc_plus4} !== 64'h0) begin n_fail++; $display("FAIL reset_idpc got=%h/%h exp=0/0", bus.id_pc, bus.id_pc_plus4); end
    n_checks++; if ({bus.stall_cnt, bus.flush_cnt} !== 64'h0) begin n_fail++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", bus.stall_cnt, bus.flush_cnt); end
  endtask

  task automatic test_sequential;
    logic [31:0] exp_instr [3];
    exp_instr[0] = 32'hA; exp_instr[1] = 32'hB; exp_instr[2] = 32'hC;
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (bus.imem_addr !== 32'(i * 4)) begin n_fail++; $display("FAIL seq_addr%0d got=%h exp=%h", i, bus.imem_addr, 32'(i * 4)); end
      cyc(0, 0, 0, 32'h0);
      n_checks++; if (bus.id_instr !== exp_instr[i]) begin n_fail++; $display("FAIL seq_instr%0d got=%h exp=%h", i, bus.id_instr, exp_instr[i]); end
      n_checks++; if (bus.id_pc !== 32'(i * 4) || bus.id_pc_plus4 !== 32'(i * 4 + 4)) begin n_fail++; $display("FAIL seq_idpc%0d got=%h/%h exp=%h/%h", i, bus.id_pc, bus.id_pc_plus4, 32'(i * 4), 32'(i * 4 + 4)); end
      n_checks++; if (bus.id_valid !== 1'b1) begin n_fail++; $display("FAIL seq_valid%0d got=%b exp=1", i, bus.id_valid); end
    end
    n_checks++; if (bus.imem_addr !== 32'hC) begin n_fail++; $display("FAIL seq_addr3 got=%h exp=%h", bus.imem_addr, 32'hC); end
  endtask

  task automatic test_stall;
    logic [31:0] instr_c;
    instr_c = imem_word(32'hC, salt);
    cyc(0, 0, 0, 32'h0);
    cyc(0, 1, 0, 32'h0);
    cyc(0, 1, 0, 32'h0);
    n_checks++; if (bus.imem_addr !== 32'h10) begin n_fail++; $display("FAIL stall_pc got=%h exp=%h", bus.imem_addr, 32'h10); end
    n_checks++; if (bus.id_instr !== instr_c || bus.id_pc !== 32'hC || bus.id_pc_plus4 !== 32'h10 || bus.id_valid !== 1'b1) begin
      n_fail++; $display("FAIL stall_frozen got=%h/%h/%h/%b exp=%h/0000000c/00000010/1", bus.id_instr, bus.id_pc, bus.id_pc_plus4, bus.id_valid, instr_c);
    end
    n_checks++; if (bus.stall_cnt !== 32'd2 || bus.flush_cnt !== 32'd0) begin n_fail++; $display("FAIL stall_cnt got=%0d/%0d exp=2/0", bus.stall_cnt, bus.flush_cnt); end
  endtask

  task automatic test_redirect;
    cyc(0, 0, 1, 32'h20);
    cyc(0, 0, 1, 32'h103);
    n_checks++; if (bus.imem_addr !== 32'h100) begin n_fail++; $display("FAIL redir_pc got=%h exp=%h", bus.imem_addr, 32'h100); end
    n_checks++; if (bus.id_instr !== NOP || bus.id_valid !== 1'b0 || bus.id_pc !== 32'h0) begin n_fail++; $display("FAIL redir_bubble got=%h/%b/%h exp=%h/0/0", bus.id_instr, bus.id_valid, bus.id_pc, NOP); end
    n_checks++; if (bus.flush_cnt !== 32'd2) begin n_fail++; $display("FAIL redir_fcnt got=%0d exp=2", bus.flush_cnt); end
    cyc(0, 0, 0, 32'h0);
    n_checks++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h100 || bus.imem_addr !== 32'h104) begin n_fail++; $display("FAIL redir_resume got=%b/%h/%h exp=1/00000100/00000104", bus.id_valid, bus.id_pc, bus.imem_addr); end
    cyc(0, 0, 1, 32'h104);
    n_checks++; if (bus.imem_addr !== 32'h104 || bus.id_valid !== 1'b0 || bus.flush_cnt !== 32'd3) begin n_fail++; $display("FAIL self_loop got=%h/%b/%0d exp=00000104/0/3", bus.imem_addr, bus.id_valid, bus.flush_cnt); end
  endtask

  task automatic test_stall_and_branch;
    cyc(0, 1, 1, 32'h200);
    n_checks++; if (bus.imem_addr !== 32'h104 || bus.flush_cnt !== 32'd3 || bus.stall_cnt !== 32'd3) begin n_fail++; $display("FAIL sb_hold got=%h/%0d/%0d exp=00000104/3/3", bus.imem_addr, bus.flush_cnt, bus.stall_cnt); end
    cyc(0, 0, 1, 32'h200);
    n_checks++; if (bus.imem_addr !== 32'h200 || bus.flush_cnt !== 32'd4 || bus.id_valid !== 1'b0) begin n_fail++; $display("FAIL sb_accept got=%h/%0d/%b exp=00000200/4/0", bus.imem_addr, bus.flush_cnt, bus.id_valid); end
  endtask

  task automatic test_wrap;
    cyc(0, 0, 1, 32'hFFFF_FFFE);
    n_checks++; if (bus.imem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_target got=%h exp=fffffffc", bus.imem_addr); end
    cyc(0, 0, 0, 32'h0);
    n_checks++; if (bus.imem_addr !== 32'h0 || bus.id_pc !== 32'hFFFF_FFFC || bus.id_pc_plus4 !== 32'h0) begin n_fail++; $display("FAIL wrap_seq got=%h/%h/%h exp=00000000/fffffffc/00000000", bus.imem_addr, bus.id_pc, bus.id_pc_plus4); end
  endtask

  task automatic test_reset_midop;
    cyc(0, 0, 1, 32'h40);
    cyc(0, 1, 0, 32'h0);
    cyc(0, 1, 0, 32'h0);
    n_checks++; if (bus.imem_addr !== 32'h40 || bus.stall_cnt !== 32'd5) begin n_fail++; $display("FAIL midop_pre got=%h/%0d exp=00000040/5", bus.imem_addr, bus.stall_cnt); end
    cyc(1, 1, 1, 32'h80);
    n_checks++; if (bus.imem_addr !== 32'h0 || bus.stall_cnt !== 32'd0 || bus.flush_cnt !== 32'd0 || bus.id_valid !== 1'b0) begin
      n_fail++; $display("FAIL midop_rst got=%h/%0d/%0d/%b exp=00000000/0/0/0", bus.imem_addr, bus.stall_cnt, bus.flush_cnt, bus.id_valid);
    end
  endtask

  task automatic test_random;
    int bad;
    bad = 0;
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), $urandom);
      n_checks++;
      if (bus.imem_addr !== m_pc || bus.id_instr !== m_instr || bus.id_pc !== m_id_pc ||
          bus.id_pc_plus4 !== m_id_pc4 || bus.id_valid !== m_valid ||
          bus.stall_cnt !== m_sc || bus.flush_cnt !== m_fc) begin
        n_fail++;
        if (bad < 5) $display("FAIL rand_cyc%0d got pc=%h i=%h ipc=%h ip4=%h v=%b sc=%0d fc=%0d exp pc=%h i=%h ipc=%h ip4=%h v=%b sc=%0d fc=%0d",
          i, bus.imem_addr, bus.id_instr, bus.id_pc, bus.id_pc_plus4, bus.id_valid, bus.stall_cnt, bus.flush_cnt,
          m_pc, m_instr, m_id_pc, m_id_pc4, m_valid, m_sc, m_fc);
        bad++;
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    salt     = $urandom;
    rst = 1'b1; bus.stall = 1'b0; bus.branch_taken = 1'b0; bus.branch_target = 32'h0;
    m_pc = 0; m_instr = NOP; m_id_pc = 0; m_id_pc4 = 0; m_valid = 0; m_sc = 0; m_fc = 0;
    @(posedge clk);
    #1;
    test_reset;
    test_sequential;
    test_stall;
    test_redirect;
    test_stall_and_branch;
    test_wrap;
    test_reset_midop;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
